// File: rtl/regmask_encoder.sv
// regmask_encoder
//   Sequential 32-to-5 encoder. A captured register mask is drained one set
//   bit at a time, lowest index first, each index offered on a valid/ready
//   handshake. This is the inverse of the register-file write-select decode.
//
// Ports
//   clock       system clock, all state updates on the rising edge
//   ctrl_reset  synchronous active-high reset
//   in_mask     register mask to encode, bit i means register i
//   in_valid    in_mask is valid this cycle
//   in_ready    block can accept a mask (only while idle)
//   out_index   index of the lowest set bit still pending
//   out_valid   out_index is valid
//   out_ready   consumer takes out_index this cycle
//   out_last    out_index is the final pending bit of the current mask
//   remaining   number of set bits still pending (0..32)
//   done        one-cycle pulse when the current mask is fully drained
//
// Every output is either a register or decoded purely from registered
// state, so there is no combinational path from in_mask/in_valid.
module regmask_encoder #(
   parameter int NREG = 32,
   parameter int IDXW = 5
) (
   input  logic            clock,
   input  logic            ctrl_reset,
   input  logic [31:0]     in_mask,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [4:0]      out_index,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_last,
   output logic [5:0]      remaining,
   output logic            done
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t            state;
   logic [NREG-1:0]   pend;
   logic [5:0]        cnt;
   logic              done_r;

   // Position of the lowest set bit; zero for an empty mask so the idle
   // value of out_index matches its reset value.
   function automatic logic [IDXW-1:0] lsb_index(input logic [NREG-1:0] m);
      lsb_index = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (m[i]) lsb_index = IDXW'(i);
      end
   endfunction

   function automatic logic [5:0] popcount(input logic [NREG-1:0] m);
      popcount = '0;
      for (int i = 0; i < NREG; i++) begin
         popcount = popcount + {5'b0, m[i]};
      end
   endfunction

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         state  <= IDLE;
         pend   <= '0;
         cnt    <= '0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (in_mask != '0) begin
                     pend  <= in_mask;
                     cnt   <= popcount(in_mask);
                     state <= EMIT;
                  end else begin
                     // Empty mask drains immediately: done without any index.
                     done_r <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  // m & (m-1) clears exactly the lowest set bit.
                  pend <= pend & (pend - {{(NREG-1){1'b0}}, 1'b1});
                  cnt  <= cnt - 6'd1;
                  if (cnt == 6'd1) begin
                     state  <= IDLE;
                     done_r <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == EMIT);
   assign out_index = lsb_index(pend);
   assign out_last  = (cnt == 6'd1);
   assign remaining = cnt;
   assign done      = done_r;

endmodule

// File: tb/tb_regmask_encoder.sv
module tb_regmask_encoder;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic [31:0] in_mask;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  out_index;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [5:0]  remaining;
   logic        done;

   int n_checks = 0;
   int n_pass   = 0;

   regmask_encoder dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .in_mask    (in_mask),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_index  (out_index),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .remaining  (remaining),
      .done       (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_idle(input string tag, input logic exp_done);
      chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".remaining"}, 32'(remaining), 32'd0);
      chk({tag, ".out_last"},  32'(out_last),  32'd0);
      chk({tag, ".done"},      32'(done),      32'(exp_done));
   endtask

   // Present one mask while idle and drain it against a reference queue of
   // set-bit positions. stall: initial cycles with out_ready low.
   // rnd_rdy: randomise out_ready afterwards. junk: keep offering junk_mask
   // on in_valid during the drain (must be ignored).
   task automatic run_mask(input string tag, input logic [31:0] mask, input int stall,
                           input bit rnd_rdy, input bit junk, input logic [31:0] junk_mask);
      int q[$];
      int cyc;
      logic rdy;
      for (int b = 0; b < 32; b++) if (mask[b]) q.push_back(b);
      chk({tag, ".pre_in_ready"}, 32'(in_ready), 32'd1);
      in_mask  = mask;
      in_valid = 1'b1;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      in_mask  = $urandom;
      if (q.size() == 0) begin
         chk_idle({tag, ".zero"}, 1'b1);
         step();
         chk({tag, ".zero_done_clr"}, 32'(done), 32'd0);
         chk({tag, ".zero_no_valid"}, 32'(out_valid), 32'd0);
         return;
      end
      cyc = 0;
      while (q.size() > 0) begin
         if (cyc > 400) begin
            chk({tag, ".timeout"}, 32'(q.size()), 32'd0);
            return;
         end
         chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
         chk({tag, ".out_index"}, 32'(out_index), 32'(q[0]));
         chk({tag, ".remaining"}, 32'(remaining), 32'(q.size()));
         chk({tag, ".out_last"},  32'(out_last),  32'(q.size() == 1));
         chk({tag, ".in_ready"},  32'(in_ready),  32'd0);
         chk({tag, ".done"},      32'(done),      32'd0);
         if (cyc < stall) rdy = 1'b0;
         else if (rnd_rdy && cyc < 200) rdy = 1'($urandom_range(0, 1));
         else rdy = 1'b1;
         out_ready = rdy;
         if (junk) begin
            in_valid = 1'b1;
            in_mask  = junk_mask;
         end
         step();
         if (rdy) void'(q.pop_front());
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk_idle({tag, ".end"}, 1'b1);
      step();
      chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, ".post_no_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] m;
      ctrl_reset = 1'b1;
      in_mask    = 32'hFFFF_FFFF;
      in_valid   = 1'b1;
      out_ready  = 1'b1;
      step();
      step();
      // Reset dominates in_valid: still idle with reset values.
      chk_idle("reset", 1'b0);
      chk("reset.out_index", 32'(out_index), 32'd0);
      ctrl_reset = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      step();
      chk_idle("reset_rel", 1'b0);

      run_mask("m80000001", 32'h8000_0001, 0, 1'b0, 1'b0, 32'h0);
      run_mask("mFFFFFFFF", 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h0);
      run_mask("m00000000", 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0);
      run_mask("m00000024", 32'h0000_0024, 3, 1'b0, 1'b0, 32'h0);

      // Reset in the middle of a drain.
      in_mask  = 32'h0000_00F0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("rstmid.idx0", 32'(out_index), 32'd4);
      out_ready = 1'b1;
      step();
      chk("rstmid.idx1", 32'(out_index), 32'd5);
      chk("rstmid.rem1", 32'(remaining), 32'd3);
      ctrl_reset = 1'b1;
      step();
      ctrl_reset = 1'b0;
      out_ready  = 1'b0;
      chk_idle("rstmid.after", 1'b0);
      chk("rstmid.out_index", 32'(out_index), 32'd0);
      step();
      chk("rstmid.no_done", 32'(done), 32'd0);
      chk("rstmid.still_idle", 32'(out_valid), 32'd0);

      // in_valid during EMIT is ignored; the mask is taken only when re-presented.
      run_mask("ignore", 32'h0000_0003, 0, 1'b0, 1'b1, 32'hFFFF_0000);
      run_mask("represent", 32'hFFFF_0000, 0, 1'b1, 1'b0, 32'h0);

      // Randomised masks, densities and consumer back-pressure.
      for (int k = 0; k < 25; k++) begin
         case ($urandom_range(0, 4))
            0: m = 32'h0;
            1: m = 32'h1 << $urandom_range(0, 31);
            2: m = $urandom & $urandom & $urandom;
            default: m = $urandom;
         endcase
         run_mask($sformatf("rnd%0d", k), m, int'($urandom_range(0, 2)), 1'b1,
                  1'($urandom_range(0, 1)), $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regmask_encoder.md
Name: regmask_encoder

Overview:
- Sequential 32-to-5 encoder. It is the inverse of the register-file write-select decoding path.
- Accepts a 32-bit register mask, one bit per register, and emits the 5-bit index of each set bit, lowest index first. Each index is delivered over a valid/ready handshake.
- Used by multi-register operations and by register-file scrub/dump sequencing to turn a bitmask into a stream of register numbers.

Parameters:
- NREG, 32: mask width, one bit per register; fixed at 32 for this design.
- IDXW, 5: index width; must equal log2(NREG).

Ports:
- clock  input  1  system clock; all state updates on its rising edge
- ctrl_reset  input  1  synchronous, active-high reset
- in_mask  input  32  register mask to encode; bit i means register i
- in_valid  input  1  in_mask is valid this cycle
- in_ready  output  1  block can accept a mask; high only in IDLE
- out_index  output  5  index of the lowest set bit still pending
- out_valid  output  1  out_index is valid
- out_ready  input  1  consumer takes out_index this cycle
- out_last  output  1  out_index is the final pending bit of the current mask
- remaining  output  6  number of set bits still pending (0..32)
- done  output  1  one-cycle pulse: current mask fully drained

Behaviour:
- Reset, synchronous on a clock edge with ctrl_reset=1:
  - pending-mask register = 0, state = IDLE
  - in_ready=1, out_valid=0, out_last=0, out_index=0, remaining=0, done=0
  - Reset overrides every other input in the same cycle.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - If in_valid=1 at edge T, in_mask is captured.
    - Captured mask nonzero: state goes to EMIT. At T+1, out_valid=1, out_index = lowest set bit, remaining = popcount(in_mask).
    - Captured mask zero: state stays IDLE, done=1 at T+1, no out_valid ever.
- EMIT:
  - in_ready=0. in_valid is ignored; no capture and no queuing.
  - out_index = position of the lowest set bit of the pending mask; out_valid=1.
  - out_last=1 iff remaining==1.
  - Handshake (out_valid and out_ready high at edge T):
    - That bit is cleared and remaining decrements.
    - If it was the last bit, state goes to IDLE and at T+1: in_ready=1, out_valid=0, done=1 for exactly one cycle.
    - Otherwise, out_index shows the next lowest set bit at T+1.
  - out_ready=0: out_index, out_valid, out_last and remaining hold stable. No change may occur while out_valid=1 until the handshake.
- Throughput:
  - One index per cycle while out_ready stays high.
  - A mask of N set bits (N>=1) drains in exactly N cycles after the first out_valid.
  - Minimum one idle cycle (in_ready=1) between consecutive masks; no capture and emit in the same cycle.
- Index 31 (mask bit 31) must encode as 5'b11111. Mask bit i always maps to index i; no wrap-around, no offset.
- remaining is always equal to popcount of the pending mask. remaining==0 iff state==IDLE.
- done is 0 in every cycle except the pulses defined above.
- Reset mid-EMIT:
  - Pending bits are discarded with no done pulse.
  - Outputs take reset values the cycle after the reset edge.
- Outputs are registered or decoded only from registered state. There is no combinational path from in_mask or in_valid to any output.

Test Plan:
- Reset then in_mask=32'h80000001, out_ready=1:
  - out_index 0 (out_last=0, remaining=2), then 31 (out_last=1, remaining=1).
  - Next cycle: done=1, in_ready=1.
- in_mask=32'hFFFFFFFF, out_ready held 1:
  - Indices 0..31 on 32 consecutive cycles; remaining goes 32 down to 1.
  - out_last only with index 31; done one cycle after.
- in_mask=32'h00000000 accepted:
  - out_valid stays 0; done=1 the next cycle; in_ready stays 1; remaining=0.
- in_mask=32'h00000024 with out_ready=0 for 3 cycles:
  - out_index holds 2 (remaining=2) throughout.
  - Raise out_ready: 2, then 5 (out_last=1), then done.
- in_mask=32'h000000F0, one handshake (index 4), then ctrl_reset=1 for one cycle:
  - Next cycle: out_valid=0, remaining=0, in_ready=1, done never pulses.
- During EMIT of 32'h00000003, drive in_valid=1 with in_mask=32'hFFFF0000:
  - Ignored; only indices 0 and 1 are emitted.
  - The new mask is accepted only when re-presented after in_ready returns to 1.
